// File: rtl/pass_tx_pkg.sv
// Shared definitions for the dual-rail RZ transmitter: FSM encoding, link symbols, default timing.
package pass_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYM  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // {x, y} order; 2'b11 is never driven
  localparam logic [1:0] LINK_IDLE = 2'b00;
  localparam logic [1:0] LINK_ONE  = 2'b01;
  localparam logic [1:0] LINK_ZERO = 2'b10;

  localparam int DEF_BIT_CYC = 2;
  localparam int DEF_GAP_CYC = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pass_tx_if.sv
// Word-side valid/ready handshake into the transmitter; master is the word source.
interface pass_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/pass_sym_timer.sv
// Load/terminal-count down-counter timing symbol and gap holds; tc is high while the count is zero.
// Loading N-1 on entry to a state yields exactly N cycles in that state; never wraps below zero.
module pass_sym_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/pass_tx.sv
// Serializes a word MSB-first as dual-rail RZ symbols on (x, y); accept-to-first-symbol is one cycle.
// ready_out is high only in IDLE, so the source is stalled for the whole frame.
module pass_tx
  import pass_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  pass_tx_if.slave    word,
  output logic        x_out,
  output logic        y_out,
  output logic        busy,
  output logic        done
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = $clog2(max2(BIT_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] BIT_LD = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tc;
  logic [1:0]        link_nxt;

  pass_sym_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
      x_out <= 1'b0;
      y_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      sreg           <= sreg_nxt;
      idx            <= idx_nxt;
      {x_out, y_out} <= link_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idx_nxt   = idx;
    tmr_load  = 1'b0;
    tmr_val   = BIT_LD;
    case (state)
      IDLE: begin
        if (word.valid_in) begin
          state_nxt = SYM;
          sreg_nxt  = word.data_in;
          idx_nxt   = IDX_TOP;
          tmr_load  = 1'b1;
          tmr_val   = BIT_LD;
        end
      end
      SYM: begin
        if (tc) begin
          state_nxt = GAP;
          tmr_load  = 1'b1;
          tmr_val   = GAP_LD;
        end
      end
      GAP: begin
        if (tc) begin
          if (idx == '0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SYM;
            sreg_nxt  = sreg << 1;
            idx_nxt   = idx - 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = BIT_LD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Link pins are registered, so the code is derived from the state being entered
  always_comb begin
    link_nxt = LINK_IDLE;
    if (state_nxt == SYM) begin
      link_nxt = sreg_nxt[DATA_W-1] ? LINK_ONE : LINK_ZERO;
    end
  end

  assign word.ready_out = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == GAP) && tc && (idx == '0);
endmodule

// File: tb/tb_pass_tx.sv
// Directed and random frames on two transmitter configurations, checked cycle by cycle against a slot model.
module tb_pass_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  pass_tx_if #(.DATA_W(8)) ia ();
  pass_tx_if #(.DATA_W(4)) ib ();
  logic xa, ya, busya, donea;
  logic xb, yb, busyb, doneb;

  pass_tx #(.DATA_W(8), .BIT_CYC(2), .GAP_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .word(ia.slave),
    .x_out(xa), .y_out(ya), .busy(busya), .done(donea)
  );
  pass_tx #(.DATA_W(4), .BIT_CYC(1), .GAP_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .word(ib.slave),
    .x_out(xb), .y_out(yb), .busy(busyb), .done(doneb)
  );

  // receive-side pass gates
  wire pass_a = ~xa & ya;
  wire pass_b = ~xb & yb;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] IDLE_VEC = 6'b000001;  // {x, y, pass, busy, done, ready}

  task automatic sample(input int dut, output logic [5:0] v);
    if (dut == 0) v = {xa, ya, pass_a, busya, donea, ia.ready_out};
    else          v = {xb, yb, pass_b, busyb, doneb, ib.ready_out};
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp, input int cyc);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Cycle c (1-based after accept) falls in slot (c-1)/(B+G): symbol for the first B cycles, spacer after.
  function automatic logic [5:0] exp_vec(input int w, input int b, input int g,
                                         input logic [31:0] word, input int c, input int len);
    int   slot, pos;
    logic bit_v, sym;
    slot  = (c - 1) / (b + g);
    pos   = (c - 1) % (b + g);
    bit_v = word[w - 1 - slot];
    sym   = (pos < b);
    return {sym & ~bit_v, sym & bit_v, sym & bit_v, 1'b1, (c == len), 1'b0};
  endfunction

  task automatic offer(input int dut, input logic [31:0] w);
    if (dut == 0) begin ia.data_in = w[7:0]; ia.valid_in = 1'b1; end
    else          begin ib.data_in = w[3:0]; ib.valid_in = 1'b1; end
  endtask

  // Called at a negedge with the word already offered; returns at the negedge after the frame.
  task automatic frame(input int dut, input logic [31:0] word, input bit hold, input int stop_at);
    int w, b, g, len;
    logic [5:0] v;
    w   = (dut == 0) ? 8 : 4;
    b   = (dut == 0) ? 2 : 1;
    g   = (dut == 0) ? 1 : 3;
    len = w * (b + g);
    sample(dut, v);
    chk("pre_accept", v, IDLE_VEC, 0);
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (dut == 0) begin
        if (!hold) ia.valid_in = 1'b0;
        ia.data_in = 8'($urandom);
      end else begin
        if (!hold) ib.valid_in = 1'b0;
        ib.data_in = 4'($urandom);
      end
      sample(dut, v);
      chk("frame", v, exp_vec(w, b, g, word, c, len), c);
      if (c == stop_at) return;
    end
    @(negedge clk);
    sample(dut, v);
    chk("post_frame", v, IDLE_VEC, len + 1);
  endtask

  initial begin
    logic [5:0]  v;
    logic [31:0] rw;
    bit          hold;

    rst_n = 1'b0;
    ia.valid_in = 1'b0; ia.data_in = '0;
    ib.valid_in = 1'b0; ib.data_in = '0;
    repeat (3) @(negedge clk);
    sample(0, v); chk("reset_a", v, IDLE_VEC, 0);
    sample(1, v); chk("reset_b", v, IDLE_VEC, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample(0, v); chk("idle_a", v, IDLE_VEC, i);
      sample(1, v); chk("idle_b", v, IDLE_VEC, i);
    end

    offer(0, 32'hA5); frame(0, 32'hA5, 1'b0, 0);
    offer(0, 32'hFF); frame(0, 32'hFF, 1'b0, 0);
    offer(0, 32'h00); frame(0, 32'h00, 1'b0, 0);

    // back-to-back with valid held high: one idle cycle between frames
    offer(0, 32'h3C); frame(0, 32'h3C, 1'b1, 0);
    offer(0, 32'hC3); frame(0, 32'hC3, 1'b0, 0);

    // asynchronous reset inside bit 3 of 0x5A
    offer(0, 32'h5A); frame(0, 32'h5A, 1'b0, 10);
    #2 rst_n = 1'b0;
    #1 sample(0, v); chk("async_reset", v, IDLE_VEC, 0);
    @(negedge clk);
    sample(0, v); chk("in_reset", v, IDLE_VEC, 1);
    rst_n = 1'b1;
    @(negedge clk);
    sample(0, v); chk("after_reset", v, IDLE_VEC, 2);
    offer(0, 32'h81); frame(0, 32'h81, 1'b0, 0);

    offer(1, 32'h9); frame(1, 32'h9, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      rw   = $urandom;
      hold = (i < 3) && ($urandom_range(0, 1) == 1);
      offer(0, rw); frame(0, {24'h0, rw[7:0]}, hold, 0);
    end
    for (int i = 0; i < 3; i++) begin
      rw   = $urandom;
      hold = (i < 2) && ($urandom_range(0, 1) == 1);
      offer(1, rw); frame(1, {28'h0, rw[3:0]}, hold, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
